// File: rtl/datapath_sequencer.sv
// datapath_sequencer
// Queues {a, b, op} commands in a small FIFO and issues them one at a time to
// an external datapath. It waits out the datapath's pipeline latency, captures
// the result, and holds it for a valid/ready consumer.
module datapath_sequencer #(
  parameter int N     = 16,
  parameter int PIPE  = 0,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic signed [N-1:0] cmd_a,
  input  logic signed [N-1:0] cmd_b,
  input  logic [2:0]          cmd_op,
  output logic [N-1:0]        dp_A,
  output logic [N-1:0]        dp_B,
  output logic [2:0]          dp_opcode,
  input  logic signed [N-1:0] dp_Y,
  input  logic                dp_co,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [N-1:0]        res_y,
  output logic                res_co,
  output logic [2:0]          res_op,
  output logic                busy,
  output logic [15:0]         ops_done
);

  // Pointer width; DEPTH is a power of two, so pointers wrap for free.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // The count needs one extra bit to represent "full".
  localparam int CW = AW + 1;
  // One FIFO entry holds {a, b, op}.
  localparam int EW = 2 * N + 3;
  // The wait counter only has to hold the value PIPE.
  localparam int CNTW = (PIPE > 1) ? $clog2(PIPE + 1) : 1;

  localparam logic [CW-1:0]   FULL_CNT  = CW'(DEPTH);
  localparam logic [CNTW-1:0] PIPE_LOAD = CNTW'(PIPE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    RESULT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [EW-1:0] fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic [N-1:0]  head_a;
  logic [N-1:0]  head_b;
  logic [2:0]    head_op;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FULL_CNT);
  // Ready depends only on the count: a pop on the same edge does not free a
  // slot for a push while the FIFO is full.
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && cmd_ready;

  assign {head_a, head_b, head_op} = fifo_mem[rd_ptr];

  // Write the accepted command into the slot at the write pointer.
  // NOTE: the storage array has no reset. Only the pointers and the count are
  // cleared, and a slot is always written before it is read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cmd_a, cmd_b, cmd_op};
    end
  end

  // Advance the pointers and track occupancy. A simultaneous push and pop
  // leaves the count unchanged.
  // NOTE: every clocked block uses non-blocking (<=) assignments so that all
  // registers update from their pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM: IDLE -> WAIT -> RESULT -> IDLE
  // ---------------------------------------------------------------------------
  state_t          state;
  state_t          state_nxt;
  logic [CNTW-1:0] wait_cnt;
  logic            issue;
  logic            wait_tick;
  logic            capture;
  logic            retire;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Only one operation is in flight at a time.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!fifo_empty)       state_nxt = WAIT;
      WAIT:    if (wait_cnt == '0)    state_nxt = RESULT;
      RESULT:  if (res_ready)         state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // Per-state action strobes that drive the datapath and result registers.
  // NOTE: each strobe gets a default before the case statement, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    issue     = 1'b0;
    wait_tick = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
    unique case (state)
      IDLE:    issue     = !fifo_empty;
      WAIT:    begin
        capture   = (wait_cnt == '0);
        wait_tick = (wait_cnt != '0);
      end
      RESULT:  retire    = res_ready;
      default: ;
    endcase
  end

  assign pop  = issue;
  assign busy = (state != IDLE) || !fifo_empty;

  // Drive the datapath from the FIFO head. The registers hold their values
  // between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_A      <= '0;
      dp_B      <= '0;
      dp_opcode <= '0;
    end else if (issue) begin
      dp_A      <= head_a;
      dp_B      <= head_b;
      dp_opcode <= head_op;
    end
  end

  // Count down the datapath's internal register stages. The result is
  // sampled (1 + PIPE) edges after the operands are loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (issue) begin
      wait_cnt <= PIPE_LOAD;
    end else if (wait_tick) begin
      wait_cnt <= wait_cnt - CNTW'(1);
    end
  end

  // Capture the datapath outputs unmodified and hold them until the
  // consumer's handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_y     <= '0;
      res_co    <= 1'b0;
      res_op    <= '0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_y     <= dp_Y;
      res_co    <= dp_co;
      res_op    <= dp_opcode;
    end else if (retire) begin
      res_valid <= 1'b0;
    end
  end

  // Count completed result handshakes. The counter wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_done <= '0;
    end else if (retire) begin
      ops_done <= ops_done + 16'd1;
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer
// Directed bench for two instances of the sequencer. dut0 runs with PIPE=0 and
// a combinational datapath model. dut1 runs with PIPE=1 and a one-stage
// registered datapath model. Inputs are driven and outputs sampled on the
// falling clock edge.
module tb_datapath_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;

  // Free-running count of rising edges, used for latency and throughput.
  always @(posedge clk) cyc++;

  // Reference datapath: 000 add, 001 sub, 010 and, 011 or, 100 xor, others
  // pass A. co flags signed overflow for add and sub.
  function automatic logic [16:0] dp_model(input logic [15:0] a,
                                           input logic [15:0] b,
                                           input logic [2:0]  op);
    logic [15:0] r;
    logic        co;
    co = 1'b0;
    case (op)
      3'd0: begin
        r  = a + b;
        co = (a[15] == b[15]) && (r[15] != a[15]);
      end
      3'd1: begin
        r  = a - b;
        co = (a[15] != b[15]) && (r[15] != a[15]);
      end
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      default: r = a;
    endcase
    return {co, r};
  endfunction

  // ---------------- dut0: PIPE = 0 ----------------
  logic        cmd_valid0 = 1'b0;
  logic        cmd_ready0;
  logic [15:0] cmd_a0 = '0;
  logic [15:0] cmd_b0 = '0;
  logic [2:0]  cmd_op0 = '0;
  logic [15:0] dp_A0, dp_B0, dp_Y0;
  logic [2:0]  dp_op0;
  logic        dp_co0;
  logic        res_valid0;
  logic        res_ready0 = 1'b0;
  logic [15:0] res_y0;
  logic        res_co0;
  logic [2:0]  res_op0;
  logic        busy0;
  logic [15:0] ops_done0;

  assign {dp_co0, dp_Y0} = dp_model(dp_A0, dp_B0, dp_op0);

  datapath_sequencer #(.N(16), .PIPE(0), .DEPTH(4)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid0),
    .cmd_ready (cmd_ready0),
    .cmd_a     (cmd_a0),
    .cmd_b     (cmd_b0),
    .cmd_op    (cmd_op0),
    .dp_A      (dp_A0),
    .dp_B      (dp_B0),
    .dp_opcode (dp_op0),
    .dp_Y      (dp_Y0),
    .dp_co     (dp_co0),
    .res_valid (res_valid0),
    .res_ready (res_ready0),
    .res_y     (res_y0),
    .res_co    (res_co0),
    .res_op    (res_op0),
    .busy      (busy0),
    .ops_done  (ops_done0)
  );

  // ---------------- dut1: PIPE = 1 ----------------
  logic        cmd_valid1 = 1'b0;
  logic        cmd_ready1;
  logic [15:0] cmd_a1 = '0;
  logic [15:0] cmd_b1 = '0;
  logic [2:0]  cmd_op1 = '0;
  logic [15:0] dp_A1, dp_B1, dp_Y1;
  logic [2:0]  dp_op1;
  logic        dp_co1;
  logic [16:0] pipe_q = '0;
  logic        res_valid1;
  logic        res_ready1 = 1'b1;
  logic [15:0] res_y1;
  logic        res_co1;
  logic [2:0]  res_op1;
  logic        busy1;
  logic [15:0] ops_done1;

  always @(posedge clk) pipe_q <= dp_model(dp_A1, dp_B1, dp_op1);
  assign {dp_co1, dp_Y1} = pipe_q;

  datapath_sequencer #(.N(16), .PIPE(1), .DEPTH(4)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid1),
    .cmd_ready (cmd_ready1),
    .cmd_a     (cmd_a1),
    .cmd_b     (cmd_b1),
    .cmd_op    (cmd_op1),
    .dp_A      (dp_A1),
    .dp_B      (dp_B1),
    .dp_opcode (dp_op1),
    .dp_Y      (dp_Y1),
    .dp_co     (dp_co1),
    .res_valid (res_valid1),
    .res_ready (res_ready1),
    .res_y     (res_y1),
    .res_co    (res_co1),
    .res_op    (res_op1),
    .busy      (busy1),
    .ops_done  (ops_done1)
  );

  // Command table for the FIFO-full scenario, with hand-computed results.
  logic [15:0] ff_a  [6] = '{16'd10, 16'd100, 16'h00F0, 16'h0F00, 16'h00FF, 16'hFFFC};
  logic [15:0] ff_b  [6] = '{16'd20, 16'd7,   16'h0FF0, 16'h00F0, 16'h0F0E, 16'd9};
  logic [2:0]  ff_op [6] = '{3'd0,   3'd1,    3'd2,     3'd3,     3'd4,     3'd0};
  logic [15:0] ff_y  [6] = '{16'd30, 16'd93,  16'h00F0, 16'h0FF0, 16'h0FF1, 16'd5};

  // ---------------- stimulus helpers (no checking) ----------------
  // Present a command on dut0 for exactly one rising edge. Call at a negedge.
  task automatic push0(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    cmd_a0 = a; cmd_b0 = b; cmd_op0 = op; cmd_valid0 = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid0 = 1'b0;
  endtask

  // Present a command on dut1 for exactly one rising edge. Call at a negedge.
  task automatic push1(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    cmd_a1 = a; cmd_b1 = b; cmd_op1 = op; cmd_valid1 = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid1 = 1'b0;
  endtask

  // Wait, with a bound, for res_valid0. lat is the number of edges waited.
  task automatic wait_res0(output int lat);
    lat = 0;
    while (!res_valid0 && lat < 20) begin
      @(posedge clk); @(negedge clk); lat++;
    end
  endtask

  // Wait, with a bound, for res_valid1. lat is the number of edges waited.
  task automatic wait_res1(output int lat);
    lat = 0;
    while (!res_valid1 && lat < 20) begin
      @(posedge clk); @(negedge clk); lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({cmd_ready0, busy0, res_valid0, res_co0} !== 4'b1000) $display("FAIL reset_flags0: got %b want 1000", {cmd_ready0, busy0, res_valid0, res_co0}); else passed++;
    total++; if (ops_done0 !== 16'd0) $display("FAIL reset_ops_done0: got %0d want 0", ops_done0); else passed++;
    total++; if ({dp_A0, dp_B0, dp_op0} !== 35'd0) $display("FAIL reset_dp0: got %h want 0", {dp_A0, dp_B0, dp_op0}); else passed++;
    total++; if ({res_y0, res_op0} !== 19'd0) $display("FAIL reset_res0: got %h want 0", {res_y0, res_op0}); else passed++;
    total++; if ({cmd_ready1, busy1, res_valid1} !== 3'b100) $display("FAIL reset_flags1: got %b want 100", {cmd_ready1, busy1, res_valid1}); else passed++;
    rst_n = 1'b1;
  endtask

  // A single add on dut0, issued on the first edge after reset release.
  task automatic test_single;
    int lat;
    res_ready0 = 1'b1;
    cmd_a0 = 16'd5; cmd_b0 = 16'd3; cmd_op0 = 3'd0; cmd_valid0 = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid0 = 1'b0;
    total++; if (busy0 !== 1'b1) $display("FAIL first_edge_accept: busy got %b want 1", busy0); else passed++;
    wait_res0(lat);
    total++; if (lat !== 2) $display("FAIL single_latency: got %0d want 2", lat); else passed++;
    total++; if (res_y0 !== 16'd8 || res_op0 !== 3'd0) $display("FAIL single_result: got y=%0d op=%0d want y=8 op=0", res_y0, res_op0); else passed++;
    @(posedge clk); @(negedge clk);
    total++; if ({res_valid0, busy0} !== 2'b00) $display("FAIL single_retire: got valid,busy=%b want 00", {res_valid0, busy0}); else passed++;
    total++; if (ops_done0 !== 16'd1) $display("FAIL single_ops_done: got %0d want 1", ops_done0); else passed++;
  endtask

  // The same add on dut1, whose datapath has one register stage.
  task automatic test_pipe1;
    int lat;
    push1(16'd5, 16'd3, 3'd0);
    wait_res1(lat);
    total++; if (lat !== 3) $display("FAIL pipe1_latency: got %0d want 3", lat); else passed++;
    total++; if (res_y1 !== 16'd8) $display("FAIL pipe1_result: got %0d want 8", res_y1); else passed++;
    @(posedge clk); @(negedge clk);
    total++; if (ops_done1 !== 16'd1) $display("FAIL pipe1_ops_done: got %0d want 1", ops_done1); else passed++;
  endtask

  // Hold one result in RESULT, fill the FIFO with four more commands, offer a
  // fifth, then drain everything and check the order.
  task automatic test_fifo_full;
    int lat;
    int got;
    int take_t;
    logic take;
    res_ready0 = 1'b0;
    push0(ff_a[0], ff_b[0], ff_op[0]);
    wait_res0(lat);
    total++; if (res_valid0 !== 1'b1) $display("FAIL ff_first_result: res_valid got %b want 1", res_valid0); else passed++;
    for (int i = 1; i < 5; i++) begin
      total++; if (cmd_ready0 !== 1'b1) $display("FAIL ff_ready_before_push%0d: got %b want 1", i, cmd_ready0); else passed++;
      push0(ff_a[i], ff_b[i], ff_op[i]);
    end
    total++; if (cmd_ready0 !== 1'b0) $display("FAIL ff_full_ready: got %b want 0", cmd_ready0); else passed++;
    cmd_a0 = ff_a[5]; cmd_b0 = ff_b[5]; cmd_op0 = ff_op[5]; cmd_valid0 = 1'b1;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    total++; if ({cmd_ready0, res_valid0, busy0} !== 3'b011) $display("FAIL ff_held: ready,valid,busy got %b want 011", {cmd_ready0, res_valid0, busy0}); else passed++;
    res_ready0 = 1'b1;
    got = 0; take_t = -1;
    for (int t = 0; t < 60 && got < 6; t++) begin
      if (res_valid0) begin
        total++; if (res_y0 !== ff_y[got] || res_op0 !== ff_op[got]) $display("FAIL ff_order%0d: got y=%h op=%0d want y=%h op=%0d", got, res_y0, res_op0, ff_y[got], ff_op[got]); else passed++;
        got++;
      end
      take = cmd_valid0 && cmd_ready0;
      if (take && take_t < 0) take_t = t;
      @(posedge clk); @(negedge clk);
      if (take) cmd_valid0 = 1'b0;
    end
    cmd_valid0 = 1'b0;
    total++; if (got !== 6) $display("FAIL ff_result_count: got %0d want 6", got); else passed++;
    total++; if (take_t !== 2) $display("FAIL ff_fifth_accept_cycle: got %0d want 2", take_t); else passed++;
    total++; if (ops_done0 !== 16'd7) $display("FAIL ff_ops_done: got %0d want 7", ops_done0); else passed++;
  endtask

  // Stall the consumer for four cycles and check the held result is stable.
  task automatic test_stall;
    int lat;
    res_ready0 = 1'b0;
    push0(16'h7000, 16'h2000, 3'd0);
    wait_res0(lat);
    for (int i = 0; i < 4; i++) begin
      total++; if ({res_valid0, res_co0, res_op0, res_y0} !== {1'b1, 1'b1, 3'd0, 16'h9000}) $display("FAIL stall_hold%0d: got v=%b co=%b op=%0d y=%h want v=1 co=1 op=0 y=9000", i, res_valid0, res_co0, res_op0, res_y0); else passed++;
      @(posedge clk); @(negedge clk);
    end
    total++; if (ops_done0 !== 16'd7) $display("FAIL stall_ops_held: got %0d want 7", ops_done0); else passed++;
    res_ready0 = 1'b1;
    @(posedge clk); @(negedge clk);
    total++; if (res_valid0 !== 1'b0 || ops_done0 !== 16'd8) $display("FAIL stall_release: got v=%b ops=%0d want v=0 ops=8", res_valid0, ops_done0); else passed++;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    total++; if (ops_done0 !== 16'd8) $display("FAIL ready_while_idle: ops got %0d want 8", ops_done0); else passed++;
  endtask

  // Extreme values must pass through unmodified.
  task automatic test_overflow;
    int lat;
    push0(16'h7FFF, 16'h0001, 3'd0);
    wait_res0(lat);
    total++; if (res_y0 !== 16'h8000 || res_co0 !== 1'b1) $display("FAIL ovf_add: got y=%h co=%b want y=8000 co=1", res_y0, res_co0); else passed++;
    push0(16'h8000, 16'h0000, 3'd0);
    wait_res0(lat);
    total++; if (res_y0 !== 16'h8000 || res_co0 !== 1'b0) $display("FAIL min_passthru: got y=%h co=%b want y=8000 co=0", res_y0, res_co0); else passed++;
    push0(16'h7FFF, 16'h1234, 3'd5);
    wait_res0(lat);
    total++; if (res_y0 !== 16'h7FFF || res_op0 !== 3'd5) $display("FAIL max_passthru: got y=%h op=%0d want y=7fff op=5", res_y0, res_op0); else passed++;
    @(posedge clk); @(negedge clk);
    total++; if (ops_done0 !== 16'd11) $display("FAIL ovf_ops_done: got %0d want 11", ops_done0); else passed++;
  endtask

  // Three commands on consecutive edges with res_ready tied high: one result
  // every three cycles.
  task automatic test_back_to_back;
    int rt [3];
    logic [15:0] ry [3];
    int n;
    int s;
    n = 0;
    s = cyc;
    fork
      begin
        push0(16'd1, 16'd2, 3'd0);
        push0(16'd9, 16'd4, 3'd1);
        push0(16'h1234, 16'h00FF, 3'd2);
      end
      begin
        for (int t = 0; t < 30 && n < 3; t++) begin
          if (res_valid0) begin rt[n] = cyc; ry[n] = res_y0; n++; end
          @(posedge clk); @(negedge clk);
        end
      end
    join
    total++; if (n !== 3) $display("FAIL b2b_count: got %0d want 3", n); else passed++;
    if (n == 3) begin
      total++; if (rt[0] - (s + 1) !== 2) $display("FAIL b2b_latency: got %0d want 2", rt[0] - (s + 1)); else passed++;
      total++; if (rt[1] - rt[0] !== 3 || rt[2] - rt[1] !== 3) $display("FAIL b2b_interval: got %0d,%0d want 3,3", rt[1] - rt[0], rt[2] - rt[1]); else passed++;
      total++; if ({ry[0], ry[1], ry[2]} !== {16'd3, 16'd5, 16'h0034}) $display("FAIL b2b_values: got %h %h %h want 0003 0005 0034", ry[0], ry[1], ry[2]); else passed++;
    end
    total++; if (ops_done0 !== 16'd14) $display("FAIL b2b_ops_done: got %0d want 14", ops_done0); else passed++;
  endtask

  // Reset dut1 while it is in WAIT with two commands queued.
  task automatic test_reset_midop;
    int got;
    logic [15:0] first_y;
    res_ready1 = 1'b1;
    push1(16'd1, 16'd1, 3'd0);
    push1(16'd2, 16'd2, 3'd0);
    push1(16'd3, 16'd3, 3'd0);
    total++; if ({busy1, res_valid1, cmd_ready1} !== 3'b101) $display("FAIL midop_pre: busy,valid,ready got %b want 101", {busy1, res_valid1, cmd_ready1}); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if ({cmd_ready1, busy1, res_valid1, res_co1} !== 4'b1000) $display("FAIL midop_async_flags: got %b want 1000", {cmd_ready1, busy1, res_valid1, res_co1}); else passed++;
    total++; if ({dp_A1, dp_op1, res_y1, res_op1} !== 38'd0) $display("FAIL midop_async_regs: got %h want 0", {dp_A1, dp_op1, res_y1, res_op1}); else passed++;
    total++; if (ops_done1 !== 16'd0 || ops_done0 !== 16'd0) $display("FAIL midop_ops_done: got %0d,%0d want 0,0", ops_done1, ops_done0); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    cmd_a1 = 16'd7; cmd_b1 = 16'd8; cmd_op1 = 3'd0; cmd_valid1 = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid1 = 1'b0;
    total++; if (busy1 !== 1'b1) $display("FAIL midop_first_edge_accept: busy got %b want 1", busy1); else passed++;
    got = 0; first_y = '0;
    for (int t = 0; t < 12; t++) begin
      if (res_valid1) begin
        if (got == 0) first_y = res_y1;
        got++;
      end
      @(posedge clk); @(negedge clk);
    end
    total++; if (got !== 1) $display("FAIL midop_result_count: got %0d want 1", got); else passed++;
    total++; if (first_y !== 16'd15) $display("FAIL midop_no_stale: got %0d want 15", first_y); else passed++;
    total++; if (ops_done1 !== 16'd1) $display("FAIL midop_ops_after: got %0d want 1", ops_done1); else passed++;
  endtask

  // Guard against a hang anywhere in the sequence.
  initial begin
    #200000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    test_reset;
    test_single;
    test_pipe1;
    test_fifo_full;
    test_stall;
    test_overflow;
    test_back_to_back;
    test_reset_midop;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
